// File: rtl/debouncer_multi_if.sv
// Signal bundle between raw switch pins and the multi-channel debouncer.
// The slave side is the debouncer; the master side drives the pins and observes the results.
interface debouncer_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] switchIn;
  logic [CHANNELS-1:0] debounceOut;
  logic [CHANNELS-1:0] risePulse;
  logic [CHANNELS-1:0] fallPulse;
  logic                beat;

  modport master (
    output switchIn,
    input  debounceOut,
    input  risePulse,
    input  fallPulse,
    input  beat
  );

  modport slave (
    input  switchIn,
    output debounceOut,
    output risePulse,
    output fallPulse,
    output beat
  );
endinterface

// File: rtl/debouncer_multi.sv
// Multi-channel switch debouncer: 2-flop synchroniser, periodic sample beat,
// DEPTH-sample hysteresis per channel and one-cycle rise/fall pulses.
module debouncer_multi #(
  parameter int CHANNELS   = 4,
  parameter int TICK_DIV   = 3_333_333,
  parameter int DEPTH      = 3,
  parameter bit INIT_LEVEL = 1'b0
) (
  input logic              clk,
  input logic              reset,
  debouncer_multi_if.slave bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  // Newest sample enters at bit 0; older samples move toward the MSB.
  function automatic logic [DEPTH-1:0] shift_in(input logic [DEPTH-1:0] hist,
                                                input logic             sample);
    return {hist[DEPTH-2:0], sample};
  endfunction

  // A full run of ones sets, a full run of zeros clears, anything mixed holds.
  function automatic logic [CHANNELS-1:0] settle(input logic [CHANNELS-1:0] cur,
                                                 input logic [CHANNELS-1:0] ones,
                                                 input logic [CHANNELS-1:0] zeros);
    return (cur | ones) & ~zeros;
  endfunction

  logic [CNT_W-1:0]    cnt;
  logic                beat_p0;
  logic [CHANNELS-1:0] sync_p0;
  logic [CHANNELS-1:0] sync_p1;
  logic [DEPTH-1:0]    hist      [CHANNELS];
  logic [DEPTH-1:0]    hist_next [CHANNELS];
  logic [CHANNELS-1:0] all_one;
  logic [CHANNELS-1:0] all_zero;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;

  // Beat generator: registered strobe, one cycle per TICK_DIV clocks
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      beat_p0 <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      beat_p0 <= 1'b1;
    end else begin
      cnt     <= cnt + CNT_W'(1);
      beat_p0 <= 1'b0;
    end
  end

  // Stage p0/p1: two-flop synchroniser, runs every clock
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= {CHANNELS{INIT_LEVEL}};
      sync_p1 <= {CHANNELS{INIT_LEVEL}};
    end else begin
      sync_p0 <= bus.switchIn;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    all_one  = '0;
    all_zero = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      hist_next[ch] = shift_in(hist[ch], sync_p1[ch]);
      all_one[ch]   = &hist_next[ch];
      all_zero[ch]  = ~|hist_next[ch];
    end
  end

  // History/level stage: decisions use the history including the sample taken this beat
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        hist[ch] <= {DEPTH{INIT_LEVEL}};
      end
      level <= {CHANNELS{INIT_LEVEL}};
      rise  <= '0;
      fall  <= '0;
    end else if (beat_p0) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        hist[ch] <= hist_next[ch];
      end
      level <= settle(level, all_one, all_zero);
      rise  <= all_one & ~level;
      fall  <= all_zero & level;
    end else begin
      rise <= '0;
      fall <= '0;
    end
  end

  assign bus.debounceOut = level;
  assign bus.risePulse   = rise;
  assign bus.fallPulse   = fall;
  assign bus.beat        = beat_p0;

endmodule
